opponent_pos_rx: RTL
====================

# opponent_pos_rx

Packet decoder upstream of the opponent-tank drawing stage: consumes the byte stream from the UART receiver, assembles opponent tank X/Y coordinates, validates and clamps them, and presents them as `Data_out_X`/`Data_out_Y` to drive the opponent stage's `Data_in_X`/`Data_in_Y`. Coordinates update only at the vsync rising edge, so the opponent tank never tears mid-frame. A frame-based watchdog flags link loss.

## Interface
- `X_MAX`, default 752: largest legal X (800 − tank width); larger values are clamped.
- `Y_MAX`, default 552: largest legal Y (600 − tank height); larger values are clamped.
- `BYTE_GAP`, default 65000: max clk cycles between bytes inside one packet (1 ms at 65 MHz).
- `LOST_FRAMES`, default 60: frames without a good packet before `link_lost` asserts.
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle.
- `vsync`  in  1  frame sync from the timing chain, active-high.
- `Data_out_X`  out  10  opponent X, frame-stable.
- `Data_out_Y`  out  10  opponent Y, frame-stable.
- `pos_valid`  out  1  high once at least one good packet has been applied.
- `link_lost`  out  1  no good packet in the last `LOST_FRAMES` frames.
- `err_cnt`  out  8  saturating count of rejected packets.

## Operation
- Packet: byte0 header 0xA5; byte1 `{4'b0, Y[9:8], X[9:8]}` (upper nibble ignored); byte2 X[7:0]; byte3 Y[7:0]; byte4 checksum (only with `OPP_CHECKSUM_EN`).
- FSM states: IDLE → HI → XLO → YLO → (CHK) → IDLE. Advances only on `rx_valid`.
- IDLE: non-0xA5 bytes are discarded silently. Other states: 0xA5 is treated as data; there is no in-band resync.
- Gap counter resets on every accepted byte. In any state other than IDLE, reaching `BYTE_GAP` aborts to IDLE, increments `err_cnt`, and writes no pending data.
- Packet completion: X and Y are clamped to `X_MAX`/`Y_MAX`, written to pending registers, and `pend` is set. A newer good packet overwrites an unapplied pending one.
- Apply: on the vsync rising edge (`vsync & ~vsync_q`) with `pend` set, the outputs load from pending, `pend` clears, `pos_valid` sets, and the frame counter clears.
- Watchdog: the frame counter increments on each vsync rise where nothing is applied and saturates at `LOST_FRAMES`. `link_lost` is high while counter == `LOST_FRAMES`.
- `err_cnt` saturates at 255.

## Timing
- Reset values:
  - `Data_out_X` = 0, `Data_out_Y` = 0, `pos_valid` = 0.
  - `link_lost` = 1, with the frame counter preset to `LOST_FRAMES`.
  - `err_cnt` = 0, `pend` = 0, FSM in IDLE.
- The last packet byte is accepted at edge N. `pend` is visible after edge N.
- Outputs change at the first edge where the vsync rise is detected, i.e. one cycle after `vsync` is first sampled high.
- Last byte and vsync rise at the same edge: the outputs take the previous pending contents, if any. The new packet lands in pending and is applied on the next frame. If set and clear of `pend` coincide, set wins.
- `rx_valid` on consecutive cycles is supported (one byte per cycle).
- `rst` mid-packet: the partial packet is discarded and no error is counted.

## Configuration
- `OPP_CHECKSUM_EN` defined:
  - 5-byte packet; byte4 must equal byte1 ^ byte2 ^ byte3.
  - On mismatch, the packet is discarded and `err_cnt` increments.
- `OPP_CHECKSUM_EN` undefined:
  - 4-byte packet; completion occurs on byte3.
  - CHK state is absent; `err_cnt` counts gap timeouts only.

## Structure
- Package `opp_rx_pkg` holds:
  - the `OPP_HDR` = 8'hA5 constant;
  - the state enum `opp_rx_state_t`;
  - bit-field positions of byte1.
- Sub-module `opp_link_watchdog` holds the vsync edge detect and the saturating frame counter. It outputs the `vsync_rise` strobe and `link_lost`, and takes the `apply` input.

## Test plan
- Packet A5,01,2C,C8 (+chk E5), then a vsync pulse → `Data_out_X` = 300, `Data_out_Y` = 200, `pos_valid` = 1, `link_lost` = 0 one cycle after vsync is sampled high. Outputs are unchanged before vsync.
- X = 1000 (A5,03,E8,64,+chk 8F), then vsync → `Data_out_X` = 752, `Data_out_Y` = 100.
- With `OPP_CHECKSUM_EN`, packet A5,01,2C,C8,00 → outputs unchanged, `err_cnt` = 1, and a following good packet decodes correctly.
- Bytes A5,01, then 70000 idle cycles, then 2C,C8 → abort, `err_cnt` = 1. The stray bytes are discarded in IDLE and the outputs stay unchanged.
- Last byte coincides with the vsync rise → outputs hold the old value and update on the following vsync.
- After a good packet, 60 vsync pulses with no traffic → `link_lost` = 1 on the 60th rise, and `Data_out_X`/`Data_out_Y` retain their last values.

Source files
------------

// File: rtl/opponent_pos_rx_pkg.sv
// Shared constants and types for the opponent position packet decoder.
// OPP_CHECKSUM_EN adds the CHK state for the 5-byte packet format.
package opp_rx_pkg;

  localparam logic [7:0] OPP_HDR = 8'hA5;

  // byte1 layout: {4'b0, Y[9:8], X[9:8]}
  localparam int B1_XHI_LSB = 0;
  localparam int B1_YHI_LSB = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_XLO  = 3'd2,
    S_YLO  = 3'd3
`ifdef OPP_CHECKSUM_EN
    ,
    S_CHK  = 3'd4
`endif
  } opp_rx_state_t;

  function automatic logic [9:0] clamp10(
    input logic [9:0] v,
    input logic [9:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/opponent_pos_rx_if.sv
// Byte stream from the UART receiver into the position decoder.
// rx_valid is a one-cycle strobe qualifying rx_data.
interface opponent_pos_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output rx_data,
    output rx_valid
  );

  modport slave (
    input rx_data,
    input rx_valid
  );

endinterface

// File: rtl/opponent_pos_rx_watchdog.sv
// vsync rise detector plus saturating frame counter for link loss.
// The rise strobe lags vsync by one registered sample.
module opp_link_watchdog #(
  parameter int LOST_FRAMES = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  input  logic apply_i,
  output logic vsync_rise_o,
  output logic link_lost_o
);

  localparam int CW = $clog2(LOST_FRAMES + 1);
  localparam logic [CW-1:0] LOST = CW'(LOST_FRAMES);

  logic          vs_q;
  logic          vs_qq;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign vsync_rise_o = vs_q & ~vs_qq;
  assign link_lost_o  = (cnt_q == LOST);

  always_comb begin
    cnt_d = cnt_q;
    if (apply_i) begin
      cnt_d = '0;
    end else if (vsync_rise_o && cnt_q != LOST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter starts saturated so the link reads lost until a packet lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      cnt_q <= LOST;
    end else begin
      vs_q  <= vsync_i;
      vs_qq <= vs_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/opponent_pos_rx.sv
// Opponent tank position packet decoder with frame-synchronous apply.
// Define OPP_CHECKSUM_EN for the 5-byte packet with XOR checksum.
module opponent_pos_rx
  import opp_rx_pkg::*;
#(
  parameter int X_MAX       = 752,
  parameter int Y_MAX       = 552,
  parameter int BYTE_GAP    = 65000,
  parameter int LOST_FRAMES = 60
) (
  input  logic                     clk,
  input  logic                     rst,
  opponent_pos_rx_if.slave         rx,
  input  logic                     vsync,
  output logic [9:0]               Data_out_X,
  output logic [9:0]               Data_out_Y,
  output logic                     pos_valid,
  output logic                     link_lost,
  output logic [7:0]               err_cnt
);

  localparam int GAP_W = $clog2(BYTE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);
  localparam logic [9:0] XM = 10'(X_MAX);
  localparam logic [9:0] YM = 10'(Y_MAX);

  opp_rx_state_t    state_q;
  opp_rx_state_t    state_d;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;

  logic [3:0] hi_q;
  logic [7:0] xlo_q;
  logic       pend_q;
  logic [9:0] pend_x_q;
  logic [9:0] pend_y_q;
  logic [9:0] out_x_q;
  logic [9:0] out_y_q;
  logic       pos_valid_q;
  logic [7:0] err_q;

  logic       byte_v;
  logic       in_pkt;
  logic       timeout;
  logic       ld_hi;
  logic       ld_x;
  logic       done;
  logic       err_inc;
  logic       vsync_rise;
  logic       apply;
  logic [9:0] raw_x;
  logic [9:0] raw_y;

`ifdef OPP_CHECKSUM_EN
  logic [7:0] ylo_q;
  logic [7:0] sum_q;
  logic       ld_y;
`endif

  assign byte_v  = rx.rx_valid;
  assign in_pkt  = (state_q != S_IDLE);
  assign timeout = in_pkt & ~byte_v & (gap_q == GAP_LAST);
  assign apply   = vsync_rise & pend_q;

  assign raw_x = {hi_q[B1_XHI_LSB +: 2], xlo_q};
`ifdef OPP_CHECKSUM_EN
  assign raw_y = {hi_q[B1_YHI_LSB +: 2], ylo_q};
`else
  assign raw_y = {hi_q[B1_YHI_LSB +: 2], rx.rx_data};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = (byte_v || !in_pkt) ? '0 : gap_q + 1'b1;
    if (timeout) begin
      state_d = S_IDLE;
      gap_d   = '0;
    end else if (byte_v) begin
      case (state_q)
        S_IDLE: begin
          if (rx.rx_data == OPP_HDR) state_d = S_HI;
        end
        S_HI:  state_d = S_XLO;
        S_XLO: state_d = S_YLO;
`ifdef OPP_CHECKSUM_EN
        S_YLO: state_d = S_CHK;
        S_CHK: state_d = S_IDLE;
`else
        S_YLO: state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_hi   = 1'b0;
    ld_x    = 1'b0;
    done    = 1'b0;
    err_inc = 1'b0;
`ifdef OPP_CHECKSUM_EN
    ld_y    = 1'b0;
`endif
    unique case (1'b1)
      timeout:                     err_inc = 1'b1;
      byte_v && state_q == S_HI:   ld_hi   = 1'b1;
      byte_v && state_q == S_XLO:  ld_x    = 1'b1;
`ifdef OPP_CHECKSUM_EN
      byte_v && state_q == S_YLO:  ld_y    = 1'b1;
      byte_v && state_q == S_CHK: begin
        done    = (rx.rx_data == sum_q);
        err_inc = (rx.rx_data != sum_q);
      end
`else
      byte_v && state_q == S_YLO:  done    = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      xlo_q <= '0;
`ifdef OPP_CHECKSUM_EN
      ylo_q <= '0;
      sum_q <= '0;
`endif
    end else begin
      if (ld_hi) hi_q  <= rx.rx_data[3:0];
      if (ld_x)  xlo_q <= rx.rx_data;
`ifdef OPP_CHECKSUM_EN
      if (ld_y)  ylo_q <= rx.rx_data;
      // running XOR of byte1..byte3, compared against byte4
      if (ld_hi) sum_q <= rx.rx_data;
      else if (ld_x || ld_y) sum_q <= sum_q ^ rx.rx_data;
`endif
    end
  end

  // Outputs read pending before this edge's write, so a packet that
  // completes on the apply edge waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      pos_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      if (done) begin
        pend_q   <= 1'b1;
        pend_x_q <= clamp10(raw_x, XM);
        pend_y_q <= clamp10(raw_y, YM);
      end else if (apply) begin
        pend_q   <= 1'b0;
      end
      if (apply) begin
        out_x_q     <= pend_x_q;
        out_y_q     <= pend_y_q;
        pos_valid_q <= 1'b1;
      end
      if (err_inc && err_q != 8'hFF) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  opp_link_watchdog #(
    .LOST_FRAMES (LOST_FRAMES)
  ) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .vsync_i      (vsync),
    .apply_i      (apply),
    .vsync_rise_o (vsync_rise),
    .link_lost_o  (link_lost)
  );

  assign Data_out_X = out_x_q;
  assign Data_out_Y = out_y_q;
  assign pos_valid  = pos_valid_q;
  assign err_cnt    = err_q;

endmodule
